// File: rtl/mult.sv
// ---------------------------------------------------------------------------
// mult: sequential signed multiplier (radix-2 Booth, one step per clock).
//
// Produces the full 2*WIDTH-bit two's-complement product of a and b and
// presents it on high/low together with a one-cycle mult_end pulse. The
// control unit pulses MultCtrl, then waits for mult_end before latching
// the HI/LO registers.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high reset
//   MultCtrl  in   1      start request, honoured only while idle
//   a         in   WIDTH  signed multiplicand, captured at start
//   b         in   WIDTH  signed multiplier, captured at start
//   high      out  WIDTH  product bits [2*WIDTH-1:WIDTH]
//   low       out  WIDTH  product bits [WIDTH-1:0]
//   mult_end  out  1      one-cycle completion pulse
//
// Timing: start sampled at edge 0, Booth steps at edges 1..WIDTH, results
// and mult_end registered at edge WIDTH+1. All outputs are registered.
// ---------------------------------------------------------------------------
module mult #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] high,
    output logic [WIDTH-1:0] low,
    output logic             mult_end
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH:0]   acc_q;    // A: one bit wider so A - M never overflows
    logic [WIDTH:0]   mcand_q;  // M: sign-extended multiplicand
    logic [WIDTH-1:0] mplier_q; // Q: multiplier, fills with low product bits
    logic             q_m1_q;   // Q_-1
    logic [CntW-1:0]  count_q;

    logic [WIDTH:0]   acc_sum;

    // Booth add/subtract selected by the current multiplier bit pair.
    always_comb begin
        acc_sum = acc_q;
        case ({mplier_q[0], q_m1_q})
            2'b01:   acc_sum = acc_q + mcand_q;
            2'b10:   acc_sum = acc_q - mcand_q;
            default: acc_sum = acc_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            q_m1_q   <= 1'b0;
            count_q  <= '0;
            high     <= '0;
            low      <= '0;
            mult_end <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    mult_end <= 1'b0;
                    if (MultCtrl) begin
                        mcand_q  <= {a[WIDTH-1], a};
                        mplier_q <= b;
                        acc_q    <= '0;
                        q_m1_q   <= 1'b0;
                        count_q  <= CntW'(WIDTH);
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    mult_end <= 1'b0;
                    // Arithmetic right shift of {A, Q, Q_-1} after the add.
                    acc_q    <= {acc_sum[WIDTH], acc_sum[WIDTH:1]};
                    mplier_q <= {acc_sum[0], mplier_q[WIDTH-1:1]};
                    q_m1_q   <= mplier_q[0];
                    count_q  <= count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    high     <= acc_q[WIDTH-1:0];
                    low      <= mplier_q;
                    mult_end <= 1'b1;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult.sv
// ---------------------------------------------------------------------------
// tb_mult: directed self-checking bench for the Booth multiplier.
// Inputs are driven on the falling edge or 1ns after a rising edge; outputs
// are sampled 1ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_mult;

    logic        clk;
    logic        reset;
    logic        MultCtrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] high;
    logic [31:0] low;
    logic        mult_end;

    int n_checks;
    int n_fail;

    mult #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .MultCtrl (MultCtrl),
        .a        (a),
        .b        (b),
        .high     (high),
        .low      (low),
        .mult_end (mult_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // Start one operation and return the number of edges from the start edge
    // to the edge that raised mult_end (0 if it never came within 40 cycles).
    task automatic do_mult(input logic [31:0] op_a, input logic [31:0] op_b,
                           output int cycles);
        @(negedge clk);
        a        = op_a;
        b        = op_b;
        MultCtrl = 1'b1;
        @(posedge clk);
        #1;
        MultCtrl = 1'b0;
        cycles   = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (mult_end) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        MultCtrl = 1'b0;
        a        = '0;
        b        = '0;
        #1;
        n_checks++;
        if (high !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_high: got %h, expected %h", high, 32'h0);
        end
        n_checks++;
        if (low !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_low: got %h, expected %h", low, 32'h0);
        end
        n_checks++;
        if (mult_end !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mult_end: got %b, expected %b", mult_end, 1'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        do_mult(32'd3, 32'd5, cyc);
        n_checks++;
        if (cyc !== 33) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, expected %0d", cyc, 33);
        end
        n_checks++;
        if (high !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL basic_high: got %h, expected %h", high, 32'h0000_0000);
        end
        n_checks++;
        if (low !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL basic_low: got %h, expected %h", low, 32'h0000_000F);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (mult_end !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse_width: got %b, expected %b", mult_end, 1'b0);
        end
    endtask

    // Operand changes and extra MultCtrl pulses during RUN/DONE are ignored.
    task automatic test_hold_and_ignore();
        int  pulses;
        int  end_edge;
        bit  hold_bad;
        pulses   = 0;
        end_edge = 0;
        hold_bad = 1'b0;
        @(negedge clk);
        a        = 32'd2;
        b        = 32'd4;
        MultCtrl = 1'b1;
        @(posedge clk);
        #1;
        MultCtrl = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            #1;
            if (c < 33 && (high !== 32'h0 || low !== 32'd15)) hold_bad = 1'b1;
            if (mult_end) begin
                pulses++;
                end_edge = c;
            end
            if (c == 5) begin
                a        = $urandom;
                b        = $urandom;
                MultCtrl = 1'b1;
            end
            if (c == 6)  MultCtrl = 1'b0;
            if (c == 32) MultCtrl = 1'b1;
            if (c == 33) MultCtrl = 1'b0;
        end
        n_checks++;
        if (hold_bad) begin
            n_fail++;
            $display("FAIL hold_outputs: got changed outputs during run, expected 0/15 held");
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL hold_pulse_count: got %0d, expected %0d", pulses, 1);
        end
        n_checks++;
        if (end_edge !== 33) begin
            n_fail++;
            $display("FAIL hold_latency: got %0d, expected %0d", end_edge, 33);
        end
        n_checks++;
        if (high !== 32'h0 || low !== 32'd8) begin
            n_fail++;
            $display("FAIL hold_result: got %h_%h, expected %h_%h", high, low, 32'h0, 32'd8);
        end
    endtask

    task automatic test_signed();
        int cyc;
        do_mult(32'hFFFF_FFF9, 32'd6, cyc);
        n_checks++;
        if (cyc !== 33 || high !== 32'hFFFF_FFFF || low !== 32'hFFFF_FFD6) begin
            n_fail++;
            $display("FAIL signed_m7x6: got %0d %h_%h, expected 33 %h_%h",
                     cyc, high, low, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
        end
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        n_checks++;
        if (cyc !== 33 || high !== 32'h0 || low !== 32'h1) begin
            n_fail++;
            $display("FAIL signed_m1xm1: got %0d %h_%h, expected 33 %h_%h",
                     cyc, high, low, 32'h0, 32'h1);
        end
    endtask

    task automatic test_boundary();
        int cyc;
        do_mult(32'h8000_0000, 32'h8000_0000, cyc);
        n_checks++;
        if (cyc !== 33 || high !== 32'h4000_0000 || low !== 32'h0) begin
            n_fail++;
            $display("FAIL bound_minxmin: got %0d %h_%h, expected 33 %h_%h",
                     cyc, high, low, 32'h4000_0000, 32'h0);
        end
        do_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, cyc);
        n_checks++;
        if (cyc !== 33 || high !== 32'h3FFF_FFFF || low !== 32'h1) begin
            n_fail++;
            $display("FAIL bound_maxxmax: got %0d %h_%h, expected 33 %h_%h",
                     cyc, high, low, 32'h3FFF_FFFF, 32'h1);
        end
        do_mult(32'h8000_0000, 32'h7FFF_FFFF, cyc);
        n_checks++;
        if (cyc !== 33 || high !== 32'hC000_0000 || low !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL bound_minxmax: got %0d %h_%h, expected 33 %h_%h",
                     cyc, high, low, 32'hC000_0000, 32'h8000_0000);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int cyc;
        pulses = 0;
        @(negedge clk);
        a        = 32'd100;
        b        = 32'd200;
        MultCtrl = 1'b1;
        @(posedge clk);
        #1;
        MultCtrl = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (high !== 32'h0 || low !== 32'h0 || mult_end !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_immediate: got %h_%h end=%b, expected 0_0 end=0",
                     high, low, mult_end);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (mult_end) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort_no_pulse: got %0d, expected %0d", pulses, 0);
        end
        // Reset and MultCtrl together: reset wins, nothing starts.
        @(negedge clk);
        reset    = 1'b1;
        MultCtrl = 1'b1;
        a        = 32'd3;
        b        = 32'd3;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        MultCtrl = 1'b0;
        pulses   = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (mult_end) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || low !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_wins: got %0d pulses low=%h, expected 0 pulses low=0",
                     pulses, low);
        end
        do_mult(32'h0, 32'hFFFF_FFFF, cyc);
        n_checks++;
        if (cyc !== 33 || high !== 32'h0 || low !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_restart: got %0d %h_%h, expected 33 %h_%h",
                     cyc, high, low, 32'h0, 32'h0);
        end
    endtask

    // MultCtrl held for edges 0..99: starts at 0, 34, 68 -> pulses at 33, 67, 101.
    task automatic test_back_to_back();
        int  pulses;
        int  edges [3];
        bit  val_bad;
        pulses  = 0;
        val_bad = 1'b0;
        for (int i = 0; i < 3; i++) edges[i] = -1;
        @(negedge clk);
        a        = 32'd2;
        b        = 32'd2;
        MultCtrl = 1'b1;
        for (int c = 0; c <= 110; c++) begin
            @(posedge clk);
            #1;
            if (c == 99) MultCtrl = 1'b0;
            if (mult_end) begin
                if (pulses < 3) edges[pulses] = c;
                pulses++;
                if (high !== 32'h0 || low !== 32'd4) val_bad = 1'b1;
            end
        end
        n_checks++;
        if (pulses !== 3) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: got %0d, expected %0d", pulses, 3);
        end
        n_checks++;
        if (edges[0] !== 33 || edges[1] !== 67 || edges[2] !== 101) begin
            n_fail++;
            $display("FAIL b2b_pulse_edges: got %0d %0d %0d, expected 33 67 101",
                     edges[0], edges[1], edges[2]);
        end
        n_checks++;
        if (val_bad) begin
            n_fail++;
            $display("FAIL b2b_result: got a wrong product, expected 0_4 on every pulse");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_hold_and_ignore();
        test_signed();
        test_boundary();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult.md
Name: mult

Overview:
- Sequential signed multiplier; the counterpart of the datapath divider.
- Computes the full 2·WIDTH-bit two's-complement product of a and b with radix-2 Booth recoding, one step per clock.
- Drives the HI/LO register inputs for mult instructions.
- The control unit pulses MultCtrl, then waits for mult_end before latching high/low.

Parameters:
- WIDTH, 32, operand width; high and low are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- MultCtrl  input  1  start request, sampled on rising clk edge while IDLE.
- a  input  WIDTH  multiplicand, signed, captured at start.
- b  input  WIDTH  multiplier, signed, captured at start.
- high  output  WIDTH  product bits [2·WIDTH-1:WIDTH].
- low  output  WIDTH  product bits [WIDTH-1:0].
- mult_end  output  1  one-cycle completion pulse.

Behaviour:
- Reset: asynchronous, active-high; takes effect immediately, independent of clk.
  - high=0, low=0, mult_end=0.
  - State IDLE; internal accumulator, multiplier register, Q_-1 and step counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - MultCtrl=1 at a rising edge: M <- sign-extend(a) to WIDTH+1 bits; Q <- b; A <- 0 (WIDTH+1 bits); Q_-1 <- 0; count <- WIDTH; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Inspect {Q[0],Q_-1}: 01 -> A <- A+M; 10 -> A <- A-M; 00/11 -> A unchanged. All arithmetic is WIDTH+1 bits, so negating M = -2^(WIDTH-1) cannot overflow.
  - Then arithmetic right shift of the concatenation {A,Q,Q_-1} by one; A's MSB is replicated.
  - count <- count-1; when count reaches 0 (after exactly WIDTH steps) go to DONE.
- DONE (one cycle):
  - Registered on entry: high <- A[WIDTH-1:0], low <- Q, mult_end <- 1.
  - Next edge: mult_end <- 0, go to IDLE.
- Latency:
  - MultCtrl sampled at edge 0; RUN occupies edges 1..WIDTH; high/low/mult_end update at edge WIDTH+1 (33 cycles for WIDTH=32).
  - mult_end is high for exactly one cycle.
- Output hold:
  - high/low keep the previous result (or 0 after reset) throughout RUN.
  - They change only at DONE entry, and hold afterwards until the next completion or reset.
- MultCtrl while in RUN or DONE: ignored; no restart, no queueing.
- a/b changes after the start edge: no effect on the operation in flight.
- MultCtrl held high continuously: a new operation starts on the first IDLE edge after DONE, i.e. every WIDTH+2 cycles.
- Full product is always representable: no overflow flag, no exception output. Signed×signed only; no unsigned mode.
- Reset asserted mid-RUN or in DONE:
  - Aborts the operation; all outputs and state return to reset values at once.
  - No mult_end pulse is produced for the aborted operation.
- Simultaneous reset and MultCtrl: reset wins; block remains IDLE.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then MultCtrl pulse with a=3, b=5 -> mult_end rises exactly 33 cycles after the start edge; high=0x00000000, low=0x0000000F; mult_end low the following cycle.
2. a=-7 (0xFFFFFFF9), b=6 -> high=0xFFFFFFFF, low=0xFFFFFFD6; separately a=-1, b=-1 -> high=0, low=1.
3. Boundary operands:
   - a=b=0x80000000 -> high=0x40000000, low=0x00000000.
   - a=b=0x7FFFFFFF -> high=0x3FFFFFFF, low=0x00000001.
   - a=0x80000000, b=0x7FFFFFFF -> high=0xC0000000, low=0x80000000.
4. Previous result 15 held. Start a=2, b=4; during RUN change a/b to random values and pulse MultCtrl again:
   - high/low stay 0/15 until completion, then become 0/8.
   - Exactly one mult_end pulse.
5. Start a=100, b=200; assert reset asynchronously (mid-cycle) at cycle 10 -> high/low/mult_end go to 0 immediately, no mult_end pulse. After release, start a=0, b=-1 -> high=0, low=0 after 33 cycles.
6. MultCtrl held high for 100 cycles with a=b=2 -> mult_end pulses every 34 cycles; each result high=0, low=4; no missed or extra pulses.
